// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default datapath widths and the ID/EX decode bundle.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 6;

  typedef struct packed {
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  imm;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNCT_W-1:0] funct;
  } id_ex_bundle_t;

  localparam int unsigned ID_EX_W = $bits(id_ex_bundle_t);

  // All-zero bundle: zero control fields decode as a NOP in execute.
  localparam id_ex_bundle_t ID_EX_NOP = '0;

endpackage

// File: rtl/skid_slot.sv
// One-entry register plus skid entry with valid/ready handshake and flush.
// in_ready depends only on the skid valid flop, so no ready path crosses the stage.
module skid_slot #(
  parameter int unsigned      Width  = 8,
  parameter logic [Width-1:0] Bubble = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             in_xfer, drain, main_load;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  assign in_xfer   = in_valid & ~skid_valid_q & ~flush;
  assign drain     = main_valid_q & out_ready;
  assign main_load = ~main_valid_q | drain;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = Bubble;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        // Empty main slot must present the bubble so control outputs read as NOP.
        main_valid_d = 1'b0;
        main_data_d  = Bubble;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: packs the decode bundle into a skid_slot and unpacks it for execute.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = mips_pkg::DATA_W,
  parameter int unsigned REG_AW  = mips_pkg::REG_AW,
  parameter int unsigned ALUOP_W = mips_pkg::ALUOP_W,
  parameter int unsigned FUNCT_W = mips_pkg::FUNCT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  readData1_in,
  input  logic [DATA_W-1:0]  readData2_in,
  input  logic [DATA_W-1:0]  imm_in,
  input  logic [REG_AW-1:0]  rs_in,
  input  logic [REG_AW-1:0]  rt_in,
  input  logic [REG_AW-1:0]  rd_in,
  input  logic               ALUSrc_in,
  input  logic [ALUOP_W-1:0] ALUOp_in,
  input  logic [FUNCT_W-1:0] funct_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  readData1_out,
  output logic [DATA_W-1:0]  readData2_out,
  output logic [DATA_W-1:0]  imm_out,
  output logic [REG_AW-1:0]  rs_out,
  output logic [REG_AW-1:0]  rt_out,
  output logic [REG_AW-1:0]  rd_out,
  output logic               ALUSrc_out,
  output logic [ALUOP_W-1:0] ALUOp_out,
  output logic [FUNCT_W-1:0] funct_out
);

  // Flat packing keeps the width tied to this instance's parameters; field order
  // matches mips_pkg::id_ex_bundle_t.
  localparam int unsigned PayloadW = 3 * DATA_W + 3 * REG_AW + 1 + ALUOP_W + FUNCT_W;

  logic [PayloadW-1:0] in_data;
  logic [PayloadW-1:0] out_data;

  assign in_data = {readData1_in, readData2_in, imm_in, rs_in, rt_in, rd_in,
                    ALUSrc_in, ALUOp_in, funct_in};

  assign {readData1_out, readData2_out, imm_out, rs_out, rt_out, rd_out,
          ALUSrc_out, ALUOp_out, funct_out} = out_data;

  skid_slot #(
    .Width  (PayloadW),
    .Bubble ('0)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the MIPS core, sitting between decode and the ALU/execute stage. It replaces the free-running capture register with one that has valid/ready back-pressure, a one-entry skid buffer so `in_ready` is a registered signal, flush (bubble injection) and synchronous reset. The payload is the full decode bundle: operands, immediate, register addresses, ALU control and funct.

## Interface
- `DATA_W`, 32: operand and immediate width
- `REG_AW`, 5: register-address width
- `ALUOP_W`, 2: ALUOp width
- `FUNCT_W`, 6: funct field width

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge
- `rst`  in  1: synchronous, active-high reset
- `flush`  in  1: kill all held and incoming entries (branch/jump redirect)
- `in_valid`  in  1: decode presents a valid bundle
- `in_ready`  out  1: register can accept; registered, equals `~skid_valid`
- `readData1_in`, `readData2_in`, `imm_in`  in  DATA_W each: operands, sign-extended immediate
- `rs_in`, `rt_in`, `rd_in`  in  REG_AW each: register addresses
- `ALUSrc_in`  in  1; `ALUOp_in`  in  ALUOP_W; `funct_in`  in  FUNCT_W
- `out_valid`  out  1: execute-side bundle valid
- `out_ready`  in  1: execute stage consumes this cycle
- `readData1_out`, `readData2_out`, `imm_out`, `rs_out`, `rt_out`, `rd_out`, `ALUSrc_out`, `ALUOp_out`, `funct_out`  out: registered copies, same widths as inputs

## Operation
- Two slots: main (drives outputs) and skid. Each slot has a valid bit and a payload.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Main slot loads when it is empty or drains this cycle. It loads from skid if the skid is valid; otherwise it loads from the input if a transfer occurs; otherwise it goes empty.
- Skid loads when an input transfer occurs and main is valid and not draining. The skid empties when its contents move to main.
- Order is strictly FIFO. Both slots valid means `in_ready`=0 next cycle.
- Flush, when `rst`=0:
  - Both valid bits clear next edge.
  - A same-cycle input transfer is discarded.
  - An output transfer in the same cycle still counts as consumed.
  - Main-slot control fields (`ALUSrc_out`, `ALUOp_out`, `funct_out`) are zeroed, so the bubble is a NOP. Data fields may hold stale values.
- Rule: whenever `out_valid`=0, `ALUSrc_out`, `ALUOp_out` and `funct_out` are 0.
- Reset has priority over flush and over any transfer. Inputs presented while `rst`=1 are ignored.

## Timing
- Reset values: `out_valid`=0, all payload outputs 0, skid valid 0, `in_ready`=1 (during and after reset).
- Latency: bundle accepted at edge N is on the outputs with `out_valid`=1 after edge N (visible in cycle N+1) when main is empty or draining.
- Throughput: one bundle per cycle with `out_ready` held high. The skid is never used in that case.
- `out_ready` dropping with a new input arriving: the new bundle goes to skid, and `in_ready` falls the following cycle. The combinational path `out_ready`→`in_ready` is forbidden.
- Outputs hold stable while `out_valid & ~out_ready`.
- Flush takes effect at the next edge. `in_ready`=1 the cycle after a flush.
- Reset mid-stream drops both slots; no partial bundle survives.

## Structure
- Shared package `mips_pkg`:
  - widths `DATA_W`, `REG_AW`, `ALUOP_W`, `FUNCT_W`
  - packed struct `id_ex_bundle_t` (all payload fields)
  - `ID_EX_NOP` constant (control fields zero)
- Natural sub-module: `skid_slot`, a generic payload-width valid/ready one-entry-plus-skid buffer with a flush input and a parameter for the bubble value. `id_ex_pipe_reg` packs and unpacks the bundle around it.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid`=1 and `readData1_in`=32'hDEAD_BEEF -> `out_valid`=0, all outputs 0, `in_ready`=1. First accepted bundle appears only after `rst` falls.
- Streaming: 8 bundles, `readData1_in`=i, `out_ready`=1 -> outputs i=0..7 on consecutive cycles, 1-cycle latency, skid never valid.
- Back-pressure: stream with `out_ready`=0 for 3 cycles -> exactly 2 bundles held, `in_ready`=0 from the 3rd cycle. On release, bundles emerge in order with none lost or duplicated.
- Flush with both slots full plus `in_valid`=1 -> next cycle `out_valid`=0, `ALUOp_out`=0, `ALUSrc_out`=0, `funct_out`=0, `in_ready`=1. None of the 3 bundles ever appears.
- Simultaneous drain and fill: main valid, `out_ready`=1, `in_valid`=1 every cycle -> skid stays empty and `in_ready` stays 1.
- Random valid/ready/flush soak, 10k cycles: scoreboard shows the output sequence equals the accepted-input sequence minus flushed entries.
